// File: rtl/seq_tracker.sv
// Tracks an 8-code counter sequence and declares lock after LOCK_N in-order codes.
// While locked it flywheels through misses, dropping lock after MISS_N in a row.
module seq_tracker #(
    parameter int LOCK_N = 2,
    parameter int MISS_N = 3
) (
    input  logic       C,
    input  logic       nR,
    input  logic [3:0] D,
    input  logic       V,
    output logic [2:0] IDX,
    output logic [3:0] NEXT,
    output logic       LOCK,
    output logic       ERR,
    output logic [7:0] ERRCNT
);

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM,
        LOCKED
    } state_t;

    localparam logic [3:0] LN = 4'(LOCK_N);
    localparam logic [3:0] MN = 4'(MISS_N);

    function automatic logic [3:0] code_of(input logic [2:0] i);
        logic [3:0] c;
        case (i)
            3'd0:    c = 4'h5;
            3'd1:    c = 4'h2;
            3'd2:    c = 4'h3;
            3'd3:    c = 4'h9;
            3'd4:    c = 4'h4;
            3'd5:    c = 4'h8;
            3'd6:    c = 4'hC;
            default: c = 4'h6;
        endcase
        return c;
    endfunction

    // Returns {valid, index}; codes outside the table decode as invalid.
    function automatic logic [3:0] idx_of(input logic [3:0] c);
        logic [3:0] r;
        case (c)
            4'h5:    r = 4'b1000;
            4'h2:    r = 4'b1001;
            4'h3:    r = 4'b1010;
            4'h9:    r = 4'b1011;
            4'h4:    r = 4'b1100;
            4'h8:    r = 4'b1101;
            4'hC:    r = 4'b1110;
            4'h6:    r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    state_t     state;
    logic [3:0] mcnt;
    logic [3:0] miss;

    logic [3:0] dec;
    logic       dv;
    logic [2:0] di;
    logic [2:0] inc;
    logic       hit;

    always_comb begin
        dec = idx_of(D);
        dv  = dec[3];
        di  = dec[2:0];
        inc = IDX + 3'd1;
        hit = (D == NEXT);
    end

    always_ff @(negedge C) begin
        if (!nR) begin
            state  <= SEARCH;
            IDX    <= 3'd0;
            NEXT   <= 4'h0;
            LOCK   <= 1'b0;
            ERR    <= 1'b0;
            ERRCNT <= 8'd0;
            mcnt   <= 4'd0;
            miss   <= 4'd0;
        end else begin
            ERR <= 1'b0;
            if (V) begin
                unique case (state)
                    SEARCH: begin
                        if (dv) begin
                            IDX   <= di;
                            NEXT  <= code_of(di + 3'd1);
                            mcnt  <= 4'd1;
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (hit) begin
                            IDX  <= inc;
                            NEXT <= code_of(inc + 3'd1);
                            mcnt <= mcnt + 4'd1;
                            if (mcnt + 4'd1 == LN) begin
                                state <= LOCKED;
                                LOCK  <= 1'b1;
                            end
                        end else if (dv) begin
                            IDX  <= di;
                            NEXT <= code_of(di + 3'd1);
                            mcnt <= 4'd1;
                        end else begin
                            state <= SEARCH;
                            NEXT  <= 4'h0;
                            mcnt  <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        IDX <= inc;
                        if (hit) begin
                            NEXT <= code_of(inc + 3'd1);
                            miss <= 4'd0;
                        end else begin
                            ERR <= 1'b1;
                            if (ERRCNT != 8'hFF) begin
                                ERRCNT <= ERRCNT + 8'd1;
                            end
                            // Flywheel keeps counting; too many misses loses lock.
                            if (miss + 4'd1 == MN) begin
                                state <= SEARCH;
                                LOCK  <= 1'b0;
                                NEXT  <= 4'h0;
                                miss  <= 4'd0;
                                mcnt  <= 4'd0;
                            end else begin
                                NEXT <= code_of(inc + 3'd1);
                                miss <= miss + 4'd1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule
